// File: rtl/exit_keypad_controller_pkg.sv
// Shared types and timing defaults for the exit keypad controller.
// Slot and code widths are common with the parking block.
package exit_keypad_controller_pkg;

  localparam int SLOT_W = 3;
  localparam int CODE_W = 8;
  localparam int NSLOT  = 1 << SLOT_W;
  localparam int TMR_W  = 16;

  localparam int unsigned GATE_OPEN_DEF = 50;
  localparam int unsigned KEY_TMO_DEF   = 100;
  localparam int unsigned VERIFY_DEF    = 2;
  localparam int unsigned MAX_FAILS_DEF = 3;
  localparam int unsigned LOCKOUT_DEF   = 200;

  typedef enum logic [3:0] {
    S_IDLE,
    S_CODE_HI,
    S_CODE_LO,
    S_CONFIRM,
    S_REQUEST,
    S_WAIT,
    S_OPEN,
    S_DENY,
    S_LOCKOUT
  } state_t;

  function automatic logic [1:0] sat_inc(input logic [1:0] v);
    return (v == 2'd3) ? v : v + 2'd1;
  endfunction

endpackage

// File: rtl/exit_keypad_controller_if.sv
// Keypad and parking-block bundle of the exit keypad controller.
// master drives keys and occupancy; slave is the controller.
interface exit_keypad_controller_if;
  import exit_keypad_controller_pkg::*;

  logic              key_valid;
  logic [3:0]        key_data;
  logic              key_enter;
  logic              key_clear;
  logic [NSLOT-1:0]  occupied;
  logic              car_exit;
  logic [SLOT_W-1:0] exit_from;
  logic [CODE_W-1:0] exit_code;
  logic              gate_open;
  logic              denied;
  logic              locked;
  logic              busy;
  logic [1:0]        fail_count;

  modport master (
    output key_valid, key_data, key_enter, key_clear, occupied,
    input  car_exit, exit_from, exit_code, gate_open,
    input  denied, locked, busy, fail_count
  );

  modport slave (
    input  key_valid, key_data, key_enter, key_clear, occupied,
    output car_exit, exit_from, exit_code, gate_open,
    output denied, locked, busy, fail_count
  );

endinterface

// File: rtl/exit_cycle_timer.sv
// Loadable down-counter; done marks the last cycle of a loaded interval.
// Shared by the key timeout, verify wait, gate-open and lockout intervals.
module exit_cycle_timer
  import exit_keypad_controller_pkg::*;
(
  input  logic             clock,
  input  logic             g1_reset,
  input  logic             load,
  input  logic [TMR_W-1:0] value,
  output logic             done
);

  logic [TMR_W-1:0] cnt;

  always_ff @(posedge clock) begin
    if (g1_reset) begin
      cnt <= '0;
    end else if (load) begin
      cnt <= value;
    end else if (cnt != '0) begin
      cnt <= cnt - 1'b1;
    end
  end

  assign done = (cnt == TMR_W'(1));

endmodule

// File: rtl/exit_keypad_controller.sv
// Exit keypad controller: slot + 2-digit code entry, exit request,
// occupancy verification, gate drive and lockout after repeated denials.
module exit_keypad_controller
  import exit_keypad_controller_pkg::*;
#(
  parameter int unsigned GATE_OPEN_CYCLES = GATE_OPEN_DEF,
  parameter int unsigned KEY_TIMEOUT      = KEY_TMO_DEF,
  parameter int unsigned VERIFY_WAIT      = VERIFY_DEF,
  parameter int unsigned MAX_FAILS        = MAX_FAILS_DEF,
  parameter int unsigned LOCKOUT_CYCLES   = LOCKOUT_DEF
) (
  input logic                     clock,
  input logic                     g1_reset,
  exit_keypad_controller_if.slave kp
);

  state_t            st;
  logic              car_exit_r;
  logic [SLOT_W-1:0] exit_from_r;
  logic [CODE_W-1:0] exit_code_r;
  logic              gate_open_r;
  logic              denied_r;
  logic              locked_r;
  logic              busy_r;
  logic [1:0]        fails_r;

  logic              tmr_load;
  logic [TMR_W-1:0]  tmr_val;
  logic              tmr_done;
  logic              strobe;
  logic              tmo;
  logic              occ_hit;

  assign strobe  = kp.key_valid | kp.key_enter | kp.key_clear;
  assign tmo     = tmr_done & ~strobe;
  assign occ_hit = kp.occupied[exit_from_r];

  // Each interval is loaded on the edge that enters its state.
  always_comb begin
    tmr_load = 1'b0;
    tmr_val  = TMR_W'(KEY_TIMEOUT);
    unique case (st)
      S_REQUEST: begin
        tmr_load = 1'b1;
        tmr_val  = TMR_W'(VERIFY_WAIT);
      end
      S_WAIT: begin
        tmr_load = tmr_done;
        tmr_val  = TMR_W'(GATE_OPEN_CYCLES);
      end
      S_DENY: begin
        tmr_load = 1'b1;
        tmr_val  = TMR_W'(LOCKOUT_CYCLES);
      end
      S_OPEN, S_LOCKOUT: ;
      default: tmr_load = strobe;
    endcase
  end

  exit_cycle_timer u_tmr (
    .clock    (clock),
    .g1_reset (g1_reset),
    .load     (tmr_load),
    .value    (tmr_val),
    .done     (tmr_done)
  );

  always_ff @(posedge clock) begin
    if (g1_reset) begin
      st          <= S_IDLE;
      car_exit_r  <= 1'b0;
      exit_from_r <= '0;
      exit_code_r <= '0;
      gate_open_r <= 1'b0;
      denied_r    <= 1'b0;
      locked_r    <= 1'b0;
      busy_r      <= 1'b0;
      fails_r     <= '0;
    end else begin
      car_exit_r <= 1'b0;
      denied_r   <= 1'b0;
      unique case (st)
        S_IDLE: begin
          if (kp.key_valid && !kp.key_data[3]) begin
            exit_from_r <= kp.key_data[SLOT_W-1:0];
            st          <= S_CODE_HI;
            busy_r      <= 1'b1;
          end
        end
        S_CODE_HI: begin
          if (kp.key_clear || tmo) begin
            st     <= S_IDLE;
            busy_r <= 1'b0;
          end else if (kp.key_valid) begin
            exit_code_r[CODE_W-1:4] <= kp.key_data;
            st <= S_CODE_LO;
          end
        end
        S_CODE_LO: begin
          if (kp.key_clear || tmo) begin
            st     <= S_IDLE;
            busy_r <= 1'b0;
          end else if (kp.key_valid) begin
            exit_code_r[3:0] <= kp.key_data;
            st <= S_CONFIRM;
          end
        end
        S_CONFIRM: begin
          if (kp.key_clear || tmo) begin
            st     <= S_IDLE;
            busy_r <= 1'b0;
          end else if (kp.key_enter) begin
            if (occ_hit) begin
              st         <= S_REQUEST;
              car_exit_r <= 1'b1;
            end else begin
              st       <= S_DENY;
              denied_r <= 1'b1;
              fails_r  <= sat_inc(fails_r);
            end
          end
        end
        S_REQUEST: st <= S_WAIT;
        S_WAIT: begin
          // Slot still occupied means the car never left.
          if (tmr_done) begin
            if (occ_hit) begin
              st       <= S_DENY;
              denied_r <= 1'b1;
              fails_r  <= sat_inc(fails_r);
            end else begin
              st          <= S_OPEN;
              gate_open_r <= 1'b1;
              fails_r     <= '0;
            end
          end
        end
        S_OPEN: begin
          if (tmr_done) begin
            st          <= S_IDLE;
            gate_open_r <= 1'b0;
            busy_r      <= 1'b0;
          end
        end
        S_DENY: begin
          if (32'(fails_r) >= MAX_FAILS) begin
            st       <= S_LOCKOUT;
            locked_r <= 1'b1;
          end else begin
            st     <= S_IDLE;
            busy_r <= 1'b0;
          end
        end
        S_LOCKOUT: begin
          if (tmr_done) begin
            st       <= S_IDLE;
            locked_r <= 1'b0;
            fails_r  <= '0;
            busy_r   <= 1'b0;
          end
        end
        default: begin
          st     <= S_IDLE;
          busy_r <= 1'b0;
        end
      endcase
    end
  end

  assign kp.car_exit   = car_exit_r;
  assign kp.exit_from  = exit_from_r;
  assign kp.exit_code  = exit_code_r;
  assign kp.gate_open  = gate_open_r;
  assign kp.denied     = denied_r;
  assign kp.locked     = locked_r;
  assign kp.busy       = busy_r;
  assign kp.fail_count = fails_r;

endmodule

// File: tb/tb_exit_keypad_controller.sv
// Bench for exit_keypad_controller: directed scenarios, then random
// entries checked against a transaction-level outcome model.
module tb_exit_keypad_controller;

  localparam int GATE_N = 50;
  localparam int LOCK_N = 200;
  localparam int MAXF   = 3;

  logic clock = 1'b0;
  logic g1_reset;
  int   checks = 0;
  int   errors = 0;
  int   model_fails = 0;

  exit_keypad_controller_if ifc ();

  exit_keypad_controller dut (
    .clock    (clock),
    .g1_reset (g1_reset),
    .kp       (ifc)
  );

  always #5 clock = ~clock;

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic check(input string tag, input logic [31:0] obs,
                       input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clock);
    #1;
  endtask

  task automatic press(input logic v, input logic [3:0] d,
                       input logic e, input logic c);
    ifc.key_valid = v;
    ifc.key_data  = d;
    ifc.key_enter = e;
    ifc.key_clear = c;
    step();
    ifc.key_valid = 1'b0;
    ifc.key_enter = 1'b0;
    ifc.key_clear = 1'b0;
  endtask

  task automatic check_zero(input string tag);
    check({tag, ".car_exit"},   32'(ifc.car_exit),   32'd0);
    check({tag, ".exit_from"},  32'(ifc.exit_from),  32'd0);
    check({tag, ".exit_code"},  32'(ifc.exit_code),  32'd0);
    check({tag, ".gate_open"},  32'(ifc.gate_open),  32'd0);
    check({tag, ".denied"},     32'(ifc.denied),     32'd0);
    check({tag, ".locked"},     32'(ifc.locked),     32'd0);
    check({tag, ".busy"},       32'(ifc.busy),       32'd0);
    check({tag, ".fail_count"}, 32'(ifc.fail_count), 32'd0);
  endtask

  // One full entry; parking block clears the slot on car_exit if park.
  task automatic entry(input int slot, input logic [7:0] code,
                       input logic [7:0] occ, input bit park,
                       input int rst_at);
    int         n_exit = 0;
    int         n_gate = 0;
    int         n_deny = 0;
    int         n_lock = 0;
    logic [2:0] xf = '0;
    logic [7:0] xc = '0;
    bit         exp_exit, grant, lock;
    bit         idle = 0;
    exp_exit = occ[3'(slot)];
    grant    = exp_exit && park;
    ifc.occupied = occ;
    press(1'b1, 4'(slot), 1'b0, 1'b0);
    press(1'b1, code[7:4], 1'b0, 1'b0);
    press(1'b1, code[3:0], 1'b0, 1'b0);
    press(1'b0, 4'd0, 1'b1, 1'b0);
    for (int cyc = 0; cyc < 400 && !idle; cyc++) begin
      if (ifc.car_exit) begin
        n_exit++;
        xf = ifc.exit_from;
        xc = ifc.exit_code;
        if (park) ifc.occupied[xf] = 1'b0;
      end
      if (ifc.gate_open) n_gate++;
      if (ifc.denied) n_deny++;
      if (ifc.locked) n_lock++;
      if (rst_at > 0 && n_gate == rst_at) begin
        g1_reset = 1'b1;
        ifc.key_valid = 1'b1;
        ifc.key_data  = 4'd1;
        step();
        g1_reset = 1'b0;
        ifc.key_valid = 1'b0;
        check_zero("rst_open");
        check("rst_open.car_exit_seen", 32'(n_exit), 32'd1);
        model_fails = 0;
        return;
      end
      idle = !ifc.busy;
      if (!idle) begin
        ifc.key_valid = 1'($urandom);
        ifc.key_data  = 4'($urandom_range(0, 7));
        ifc.key_enter = 1'($urandom);
        ifc.key_clear = 1'($urandom);
        step();
      end
    end
    ifc.key_valid = 1'b0;
    ifc.key_enter = 1'b0;
    ifc.key_clear = 1'b0;
    if (grant) model_fails = 0;
    else model_fails = (model_fails < 3) ? model_fails + 1 : 3;
    lock = !grant && (model_fails >= MAXF);
    if (lock) model_fails = 0;
    check("entry.back_to_idle", 32'(idle), 32'd1);
    check("entry.car_exit", 32'(n_exit), exp_exit ? 32'd1 : 32'd0);
    if (exp_exit) begin
      check("entry.exit_from", 32'(xf), 32'(slot));
      check("entry.exit_code", 32'(xc), 32'(code));
    end
    check("entry.gate_cycles", 32'(n_gate), grant ? 32'(GATE_N) : 32'd0);
    check("entry.denied", 32'(n_deny), grant ? 32'd0 : 32'd1);
    check("entry.lock_cycles", 32'(n_lock), lock ? 32'(LOCK_N) : 32'd0);
    check("entry.fail_count", 32'(ifc.fail_count), 32'(model_fails));
  endtask

  int         seen;
  int         r_slot;
  logic [7:0] r_code;
  logic [7:0] r_occ;
  bit         r_park;

  initial begin
    g1_reset      = 1'b1;
    ifc.key_valid = 1'b1;
    ifc.key_data  = 4'd5;
    ifc.key_enter = 1'b1;
    ifc.key_clear = 1'b0;
    ifc.occupied  = 8'h20;
    repeat (3) step();
    check_zero("reset");
    g1_reset      = 1'b0;
    ifc.key_valid = 1'b0;
    ifc.key_enter = 1'b0;
    step();

    entry(5, 8'h3F, 8'h20, 1'b1, 0);
    entry(5, 8'h3F, 8'h20, 1'b0, 0);
    entry(0, 8'hA5, 8'hFE, 1'b1, 0);
    entry(5, 8'h3F, 8'h20, 1'b0, 0);

    press(1'b1, 4'd2, 1'b0, 1'b0);
    check("tmo.busy_start", 32'(ifc.busy), 32'd1);
    repeat (60) step();
    press(1'b1, 4'hA, 1'b0, 1'b0);
    seen = 0;
    for (int i = 1; i <= 100; i++) begin
      step();
      if (ifc.car_exit) seen++;
      if (i == 99) check("tmo.busy_99", 32'(ifc.busy), 32'd1);
    end
    check("tmo.busy_100", 32'(ifc.busy), 32'd0);
    check("tmo.car_exit", 32'(seen), 32'd0);
    check("tmo.fail_count", 32'(ifc.fail_count), 32'(model_fails));

    ifc.occupied = 8'h10;
    press(1'b1, 4'd4, 1'b0, 1'b0);
    press(1'b1, 4'd1, 1'b0, 1'b0);
    press(1'b1, 4'd2, 1'b0, 1'b0);
    press(1'b0, 4'd0, 1'b1, 1'b1);
    check("clr.busy", 32'(ifc.busy), 32'd0);
    check("clr.car_exit", 32'(ifc.car_exit), 32'd0);
    check("clr.denied", 32'(ifc.denied), 32'd0);
    press(1'b1, 4'd9, 1'b0, 1'b0);
    check("key9.busy", 32'(ifc.busy), 32'd0);
    check("key9.exit_from", 32'(ifc.exit_from), 32'd4);
    press(1'b1, 4'd3, 1'b0, 1'b0);
    press(1'b1, 4'd7, 1'b0, 1'b1);
    check("clr_hi.busy", 32'(ifc.busy), 32'd0);

    entry(6, 8'hC3, 8'h40, 1'b1, 10);
    step();

    for (int t = 0; t < 24; t++) begin
      r_slot = $urandom_range(0, 7);
      r_code = 8'($urandom);
      r_occ  = 8'($urandom) & 8'hFE;
      r_park = 1'($urandom);
      entry(r_slot, r_code, r_occ, r_park, 0);
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
